// File: rtl/rsa_modexp_if.sv
// Operand/result bundle for the modular-exponentiation engine.
// The requester drives start/base/exp/mod; the engine returns result and status.
interface rsa_modexp_if #(parameter int WIDTH = 8);
    logic                 start;
    logic [2*WIDTH-1:0]   base;
    logic [2*WIDTH-1:0]   exp;
    logic [2*WIDTH-1:0]   mod;
    logic [2*WIDTH-1:0]   result;
    logic                 finish;
    logic                 busy;
    logic                 err;
    logic [31:0]          cycle_count;

    modport master (output start, base, exp, mod,
                    input  result, finish, busy, err, cycle_count);
    modport slave  (input  start, base, exp, mod,
                    output result, finish, busy, err, cycle_count);
endinterface

// File: rtl/rsa_modexp.sv
// Left-to-right square-and-multiply modular exponentiation over a bit-serial
// shift-add modular multiplier; latency tracks the exponent's Hamming weight.
module rsa_modexp #(parameter int WIDTH = 8) (
    input  logic        clk,
    input  logic        rst,
    rsa_modexp_if.slave bus
);
    localparam int W2 = 2*WIDTH;
    localparam int IW = $clog2(W2);
    localparam logic [IW-1:0] TOP = IW'(W2-1);

    // state | meaning
    // IDLE  | waiting for start
    // SQR   | r = r*r mod n
    // MUL   | r = r*base mod n
    // DONE  | one-cycle finish, outputs just updated
    typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;
    state_t state, state_nx;

    logic [W2-1:0] n_r, base_r, exp_r, r, result_r, mul_b;
    logic [W2:0]   acc, dbl, red1, sum, red2, n_ext;
    logic [IW-1:0] bcnt, idx;
    logic [31:0]   cyc, cycle_count_r;
    logic          err_r, bad_op, last, mbit;

    assign bad_op = (bus.mod < W2'(2)) || (bus.base >= bus.mod);
    assign last   = (bcnt == '0);
    assign n_ext  = {1'b0, n_r};
    assign mul_b  = (state == MUL) ? base_r : r;
    assign mbit   = mul_b[bcnt];

    // One interleaved step: double-and-reduce, then conditional add-and-reduce.
    assign dbl  = {acc[W2-1:0], 1'b0};
    assign red1 = (dbl >= n_ext) ? dbl - n_ext : dbl;
    assign sum  = red1 + (mbit ? {1'b0, r} : '0);
    assign red2 = (sum >= n_ext) ? sum - n_ext : sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.start) state_nx = bad_op ? DONE : SQR;
            SQR:  if (last) begin
                      if (exp_r[idx])      state_nx = MUL;
                      else if (idx == '0)  state_nx = DONE;
                      else                 state_nx = SQR;
                  end
            MUL:  if (last) state_nx = (idx == '0) ? DONE : SQR;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_r           <= '0;
            base_r        <= '0;
            exp_r         <= '0;
            r             <= '0;
            acc           <= '0;
            bcnt          <= '0;
            idx           <= '0;
            cyc           <= '0;
            result_r      <= '0;
            err_r         <= 1'b0;
            cycle_count_r <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    n_r    <= bus.mod;
                    base_r <= bus.base;
                    exp_r  <= bus.exp;
                    r      <= W2'(1);
                    acc    <= '0;
                    bcnt   <= TOP;
                    idx    <= TOP;
                    cyc    <= '0;
                    if (bad_op) begin
                        result_r      <= '0;
                        err_r         <= 1'b1;
                        cycle_count_r <= '0;
                    end
                end
                SQR, MUL: begin
                    cyc <= cyc + 32'd1;
                    if (last) begin
                        r    <= red2[W2-1:0];
                        acc  <= '0;
                        bcnt <= TOP;
                        if (state_nx == SQR) idx <= idx - 1'b1;
                        if (state_nx == DONE) begin
                            result_r      <= red2[W2-1:0];
                            err_r         <= 1'b0;
                            cycle_count_r <= cyc + 32'd1;
                        end
                    end else begin
                        acc  <= red2;
                        bcnt <= bcnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result      = result_r;
    assign bus.err         = err_r;
    assign bus.cycle_count = cycle_count_r;
    assign bus.finish      = (state == DONE);
    assign bus.busy        = (state != IDLE);
endmodule
